scan_sequencer: RTL and testbench
=================================

Name: scan_sequencer

Overview:
Parametrised successor to the SLM acquisition sequencer. For each galvo position, steps through N SLM images. Each image is shown for a programmable number of VGA frames, and the camera fires after a programmable settle interval. Adds abort, galvo-ack timeout, a done strobe, galvo position readout and a configurable settle-frame count. Sits between the host settings registers, the VGA frame generator, the camera trigger line and the galvo controller.

Parameters:
IMG_W, 7, width of image count and frame ID
CYCLE_W, 16, width of display-frames-per-image
GALVO_W, 32, width of galvo position count
MS_W, 8, width of pulse-length settings (ms)
CLK_PER_MS, 50000, iCLK cycles per millisecond
SYNC_FILTER, 8, depth of frame-sync glitch filter

Ports:
iCLK in 1 clock
iRST in 1 reset
iCAM_PULSE_MS in MS_W camera trigger pulse length, ms
iGALVO_PULSE_MS in MS_W galvo trigger pulse length, ms
iNUM_IMAGES in IMG_W images per galvo position
iCYCLES_PER_IMAGE in CYCLE_W VGA frames each image is displayed after camera fire
iNUM_GALVO_POS in GALVO_W galvo positions
iSETTLE_FRAMES in 4 frame-ends to wait before camera fire
iGALVO_TIMEOUT_FRAMES in 8 frame-ends allowed for galvo ack; 0 = no timeout
iSTART in 1 start request
iWITH_GALVO in 1 galvo mode, sampled with iSTART
iABORT in 1 abort request
iGALVO_ACK in 1 galvo settled
iVGA_FRAME_SYNC in 1 raw frame sync
oCAMERA_TRIGGER out 1 camera pulse
oGALVO_TRIGGER out 1 galvo-advance pulse
oFRAME_ID out IMG_W current image index
oGALVO_POS out GALVO_W current galvo index
oBUSY out 1 high when not IDLE
oDONE out 1 one-cycle end strobe
oERR_TIMEOUT out 1 sticky galvo timeout flag

Behaviour:
- Reset iRST is asynchronous, active-high; clock is iCLK. All outputs and registers are 0 at reset; state is IDLE.
- Sync filter: SYNC_FILTER-deep shift register; filtered sync = OR of all taps. A frame_end event is a 1-cycle pulse on the filtered falling edge, registered.
- States: IDLE, LATCH, GALVO_FIRE, GALVO_WAIT, SETTLE, CAM_FIRE, DISPLAY, ADVANCE, DONE.
- IDLE: on iSTART, capture iWITH_GALVO and go to LATCH. iSTART is ignored in all other states.
- LATCH (1 cycle):
  - Capture all settings.
  - Clear oFRAME_ID, oGALVO_POS and oERR_TIMEOUT.
  - If images==0, cycles==0, or (galvo mode and positions==0): go to DONE with no pulses.
  - Otherwise go to GALVO_FIRE in galvo mode, else SETTLE.
- GALVO_FIRE (1 cycle): launch galvo timer; clear ack catch and frame counter; go to GALVO_WAIT.
- GALVO_WAIT:
  - Ack catch ORs iGALVO_ACK from the GALVO_FIRE cycle onward.
  - When the catch is set, go to SETTLE.
  - If timeout≠0 and frame_end count == timeout with no catch: set oERR_TIMEOUT and go to DONE. Ack wins when both occur in the same cycle.
- SETTLE: clear frame counter on entry; go to CAM_FIRE when count == settle. With settle 0, go to CAM_FIRE on the next cycle.
- CAM_FIRE (1 cycle): launch camera timer; go to DISPLAY with frame counter cleared.
- DISPLAY: count frame_ends; go to ADVANCE in the cycle after the count reaches cycles_per_image.
- ADVANCE (1 cycle):
  - If FRAME_ID+1 < images: increment FRAME_ID, go to SETTLE.
  - Else if galvo mode and POS+1 < positions: increment POS, set FRAME_ID=0, go to GALVO_FIRE.
  - Else go to DONE.
- DONE: oDONE=1 for exactly this cycle; go to IDLE. oFRAME_ID and oGALVO_POS hold until the next LATCH.
- Abort:
  - iABORT in any non-IDLE state forces DONE on the next edge, with highest priority.
  - Both pulse timers clear; trigger outputs are low from the DONE cycle.
  - iABORT in IDLE is a no-op.
- Pulse timer:
  - The output goes high the cycle after launch and stays high for ms×CLK_PER_MS cycles.
  - ms==0 gives no pulse.
  - A relaunch while active restarts the count.
  - The ms value is sampled at launch.
- Width rules: all compares are on full declared widths. Counters are compared before increment, so no wrap occurs. The frame-event counter is max(CYCLE_W,8) bits wide.
- oBUSY = (state≠IDLE), combinational from the state register.

Decomposition:
- Package scan_seq_pkg holds the state encoding constants and default parameter values.
- Sub-module pulse_ms_timer (params MS_W, CLK_PER_MS; ports iCLK, iRST, iLAUNCH, iCLEAR, iMS, oPULSE) is instantiated twice.
- Sync filter and edge detect stay inline.

Test Plan (CLK_PER_MS=10, SYNC_FILTER=2, frame period 100 clk):
- No galvo, images=3, cycles=2, settle=1, cam_ms=2 -> 3 camera pulses, each 20 clk. oFRAME_ID steps 0,1,2. oDONE pulses once ~9 frames after start. No galvo pulse.
- Galvo, positions=2, images=2, ack 30 clk after each galvo pulse, galvo_ms=1 -> 2 galvo pulses of 10 clk and 4 camera pulses. oGALVO_POS goes 0→1 and FRAME_ID resets to 0 at the position change.
- Galvo, timeout=3, ack never asserted -> oERR_TIMEOUT set at the 3rd frame_end, oDONE pulse, no camera pulse. The flag clears on the next start.
- iABORT mid camera pulse (DISPLAY, image 1) -> oCAMERA_TRIGGER low and oDONE in the next cycle, then IDLE. iSTART asserted during the run is ignored.
- images=0, or cycles=0 -> LATCH→DONE within 2 cycles, no pulses.
- 1-cycle sync glitch and cam_ms=0 with settle=0 -> glitch not counted as frame_end. Camera fires the cycle after SETTLE is entered. No camera pulse when ms=0.

Source files
------------

// File: rtl/scan_seq_pkg.sv
// Shared state encoding and default parameter values for the scan sequencer.
package scan_seq_pkg;

  localparam int DEF_IMG_W       = 7;
  localparam int DEF_CYCLE_W     = 16;
  localparam int DEF_GALVO_W     = 32;
  localparam int DEF_MS_W        = 8;
  localparam int DEF_CLK_PER_MS  = 50000;
  localparam int DEF_SYNC_FILTER = 8;

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_LATCH      = 4'd1,
    S_GALVO_FIRE = 4'd2,
    S_GALVO_WAIT = 4'd3,
    S_SETTLE     = 4'd4,
    S_CAM_FIRE   = 4'd5,
    S_DISPLAY    = 4'd6,
    S_ADVANCE    = 4'd7,
    S_DONE       = 4'd8
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pulse_ms_timer.sv
// Millisecond pulse generator: output rises the cycle after launch and stays
// high for iMS * CLK_PER_MS cycles; a relaunch restarts the count.
module pulse_ms_timer #(
  parameter int MS_W       = 8,
  parameter int CLK_PER_MS = 50000
) (
  input  logic            iCLK,
  input  logic            iRST,
  input  logic            iLAUNCH,
  input  logic            iCLEAR,
  input  logic [MS_W-1:0] iMS,
  output logic            oPULSE
);

  localparam int CNT_W = MS_W + $clog2(CLK_PER_MS + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (iCLEAR) begin
      cnt_d = '0;
    end else if (iLAUNCH) begin
      cnt_d = CNT_W'(iMS) * CNT_W'(CLK_PER_MS);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign oPULSE = (cnt_q != '0);

endmodule

// File: rtl/scan_sequencer.sv
// Acquisition sequencer: per galvo position, steps through N SLM images, firing
// the camera after a settle interval and holding each image for a set frame count.
module scan_sequencer
  import scan_seq_pkg::*;
#(
  parameter int IMG_W       = DEF_IMG_W,
  parameter int CYCLE_W     = DEF_CYCLE_W,
  parameter int GALVO_W     = DEF_GALVO_W,
  parameter int MS_W        = DEF_MS_W,
  parameter int CLK_PER_MS  = DEF_CLK_PER_MS,
  parameter int SYNC_FILTER = DEF_SYNC_FILTER
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic [MS_W-1:0]    iCAM_PULSE_MS,
  input  logic [MS_W-1:0]    iGALVO_PULSE_MS,
  input  logic [IMG_W-1:0]   iNUM_IMAGES,
  input  logic [CYCLE_W-1:0] iCYCLES_PER_IMAGE,
  input  logic [GALVO_W-1:0] iNUM_GALVO_POS,
  input  logic [3:0]         iSETTLE_FRAMES,
  input  logic [7:0]         iGALVO_TIMEOUT_FRAMES,
  input  logic               iSTART,
  input  logic               iWITH_GALVO,
  input  logic               iABORT,
  input  logic               iGALVO_ACK,
  input  logic               iVGA_FRAME_SYNC,
  output logic               oCAMERA_TRIGGER,
  output logic               oGALVO_TRIGGER,
  output logic [IMG_W-1:0]   oFRAME_ID,
  output logic [GALVO_W-1:0] oGALVO_POS,
  output logic               oBUSY,
  output logic               oDONE,
  output logic               oERR_TIMEOUT
);

  localparam int FCNT_W = max_int(CYCLE_W, 8);

  state_t               state_q, state_d;
  logic                 with_galvo_q, with_galvo_d;
  logic [MS_W-1:0]      cam_ms_q, cam_ms_d;
  logic [MS_W-1:0]      galvo_ms_q, galvo_ms_d;
  logic [IMG_W-1:0]     images_q, images_d;
  logic [CYCLE_W-1:0]   cycles_q, cycles_d;
  logic [GALVO_W-1:0]   positions_q, positions_d;
  logic [3:0]           settle_q, settle_d;
  logic [7:0]           timeout_q, timeout_d;
  logic [IMG_W-1:0]     frame_id_q, frame_id_d;
  logic [GALVO_W-1:0]   pos_q, pos_d;
  logic                 err_q, err_d;
  logic [FCNT_W-1:0]    cnt_q, cnt_d;
  logic                 catch_q, catch_d;
  logic [SYNC_FILTER-1:0] sync_sr_q, sync_sr_d;
  logic                 filt_prev_q, filt_prev_d;
  logic                 frame_end_q, frame_end_d;
  logic                 filt_now;

  logic                 cam_launch, galvo_launch, abort_req;
  logic [IMG_W:0]       fid_next;
  logic [GALVO_W:0]     pos_next;

  // A short low dropout inside the sync pulse is bridged by ORing the taps.
  always_comb begin
    sync_sr_d   = {sync_sr_q[SYNC_FILTER-2:0], iVGA_FRAME_SYNC};
    filt_now    = |sync_sr_q;
    filt_prev_d = filt_now;
    frame_end_d = filt_prev_q & ~filt_now;
  end

  // One extra bit keeps the "next index < limit" compares free of wrap-around.
  assign fid_next = {1'b0, frame_id_q} + {{IMG_W{1'b0}}, 1'b1};
  assign pos_next = {1'b0, pos_q} + {{GALVO_W{1'b0}}, 1'b1};

  always_comb begin
    state_d      = state_q;
    with_galvo_d = with_galvo_q;
    cam_ms_d     = cam_ms_q;
    galvo_ms_d   = galvo_ms_q;
    images_d     = images_q;
    cycles_d     = cycles_q;
    positions_d  = positions_q;
    settle_d     = settle_q;
    timeout_d    = timeout_q;
    frame_id_d   = frame_id_q;
    pos_d        = pos_q;
    err_d        = err_q;
    cnt_d        = cnt_q;
    catch_d      = catch_q;
    cam_launch   = 1'b0;
    galvo_launch = 1'b0;
    // DONE already ends the run; re-entering it would double the strobe.
    abort_req    = iABORT && (state_q != S_IDLE) && (state_q != S_DONE);

    case (state_q)
      S_IDLE: begin
        if (iSTART) begin
          with_galvo_d = iWITH_GALVO;
          state_d      = S_LATCH;
        end
      end

      S_LATCH: begin
        cam_ms_d    = iCAM_PULSE_MS;
        galvo_ms_d  = iGALVO_PULSE_MS;
        images_d    = iNUM_IMAGES;
        cycles_d    = iCYCLES_PER_IMAGE;
        positions_d = iNUM_GALVO_POS;
        settle_d    = iSETTLE_FRAMES;
        timeout_d   = iGALVO_TIMEOUT_FRAMES;
        frame_id_d  = '0;
        pos_d       = '0;
        err_d       = 1'b0;
        if ((iNUM_IMAGES == '0) || (iCYCLES_PER_IMAGE == '0) ||
            (with_galvo_q && (iNUM_GALVO_POS == '0))) begin
          state_d = S_DONE;
        end else if (with_galvo_q) begin
          state_d = S_GALVO_FIRE;
        end else begin
          cnt_d   = '0;
          state_d = S_SETTLE;
        end
      end

      S_GALVO_FIRE: begin
        galvo_launch = 1'b1;
        catch_d      = iGALVO_ACK;
        cnt_d        = '0;
        state_d      = S_GALVO_WAIT;
      end

      S_GALVO_WAIT: begin
        catch_d = catch_q | iGALVO_ACK;
        if (frame_end_q) cnt_d = cnt_q + FCNT_W'(1);
        if (catch_q) begin
          cnt_d   = '0;
          state_d = S_SETTLE;
        end else if ((timeout_q != '0) && (cnt_q == FCNT_W'(timeout_q))) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end

      S_SETTLE: begin
        if (frame_end_q) cnt_d = cnt_q + FCNT_W'(1);
        if (cnt_q == FCNT_W'(settle_q)) state_d = S_CAM_FIRE;
      end

      S_CAM_FIRE: begin
        cam_launch = 1'b1;
        cnt_d      = '0;
        state_d    = S_DISPLAY;
      end

      S_DISPLAY: begin
        if (frame_end_q) cnt_d = cnt_q + FCNT_W'(1);
        if (cnt_q == FCNT_W'(cycles_q)) state_d = S_ADVANCE;
      end

      S_ADVANCE: begin
        if (fid_next < {1'b0, images_q}) begin
          frame_id_d = fid_next[IMG_W-1:0];
          cnt_d      = '0;
          state_d    = S_SETTLE;
        end else if (with_galvo_q && (pos_next < {1'b0, positions_q})) begin
          pos_d      = pos_next[GALVO_W-1:0];
          frame_id_d = '0;
          state_d    = S_GALVO_FIRE;
        end else begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (abort_req) begin
      cam_launch   = 1'b0;
      galvo_launch = 1'b0;
      state_d      = S_DONE;
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q      <= S_IDLE;
      with_galvo_q <= 1'b0;
      cam_ms_q     <= '0;
      galvo_ms_q   <= '0;
      images_q     <= '0;
      cycles_q     <= '0;
      positions_q  <= '0;
      settle_q     <= '0;
      timeout_q    <= '0;
      frame_id_q   <= '0;
      pos_q        <= '0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
      catch_q      <= 1'b0;
      sync_sr_q    <= '0;
      filt_prev_q  <= 1'b0;
      frame_end_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      with_galvo_q <= with_galvo_d;
      cam_ms_q     <= cam_ms_d;
      galvo_ms_q   <= galvo_ms_d;
      images_q     <= images_d;
      cycles_q     <= cycles_d;
      positions_q  <= positions_d;
      settle_q     <= settle_d;
      timeout_q    <= timeout_d;
      frame_id_q   <= frame_id_d;
      pos_q        <= pos_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
      catch_q      <= catch_d;
      sync_sr_q    <= sync_sr_d;
      filt_prev_q  <= filt_prev_d;
      frame_end_q  <= frame_end_d;
    end
  end

  pulse_ms_timer #(
    .MS_W      (MS_W),
    .CLK_PER_MS(CLK_PER_MS)
  ) u_cam_timer (
    .iCLK   (iCLK),
    .iRST   (iRST),
    .iLAUNCH(cam_launch),
    .iCLEAR (abort_req),
    .iMS    (cam_ms_q),
    .oPULSE (oCAMERA_TRIGGER)
  );

  pulse_ms_timer #(
    .MS_W      (MS_W),
    .CLK_PER_MS(CLK_PER_MS)
  ) u_galvo_timer (
    .iCLK   (iCLK),
    .iRST   (iRST),
    .iLAUNCH(galvo_launch),
    .iCLEAR (abort_req),
    .iMS    (galvo_ms_q),
    .oPULSE (oGALVO_TRIGGER)
  );

  assign oFRAME_ID    = frame_id_q;
  assign oGALVO_POS   = pos_q;
  assign oERR_TIMEOUT = err_q;
  assign oBUSY        = (state_q != S_IDLE);
  assign oDONE        = (state_q == S_DONE);

endmodule

// File: tb/tb_scan_sequencer.sv
// Scoreboard bench: a run-level model queues expected pulses and end records,
// independent monitors pop and compare as the sequencer produces them.
module tb_scan_sequencer;

  localparam int IMG_W   = 7;
  localparam int CYCLE_W = 16;
  localparam int GALVO_W = 32;
  localparam int MS_W    = 8;
  localparam int CPM     = 10;
  localparam int SYNC_F  = 2;
  localparam int BOUND   = 4000;

  typedef struct {
    int images; int cycles; int settle; int positions;
    int cam_ms; int galvo_ms; int timeout;
    bit galvo; bit ack; bit glitch;
  } cfg_t;

  typedef struct { int fid; int pos; int width; } pulse_exp_t;
  typedef struct { int fid; int pos; int err; int frames; int max_lat; } done_exp_t;

  logic               clk = 1'b0;
  logic               rst;
  logic [MS_W-1:0]    cam_ms, galvo_ms;
  logic [IMG_W-1:0]   num_images;
  logic [CYCLE_W-1:0] cycles;
  logic [GALVO_W-1:0] num_pos;
  logic [3:0]         settle;
  logic [7:0]         timeout;
  logic               start, with_galvo, abort, galvo_ack, vga_sync;
  logic               cam_trig, galvo_trig, busy, done, err;
  logic [IMG_W-1:0]   frame_id;
  logic [GALVO_W-1:0] galvo_pos;

  int n_checks = 0;
  int n_pass   = 0;
  longint cyc = 0;
  int frame_cnt = 0;
  int start_frame = 0;
  longint start_cyc = 0;
  int done_seen = 0;
  int done_target = 0;
  bit glitch_en = 1'b0;
  bit ack_en = 1'b0;

  pulse_exp_t cam_q[$];
  pulse_exp_t gal_q[$];
  done_exp_t  done_q[$];

  scan_sequencer #(
    .IMG_W(IMG_W), .CYCLE_W(CYCLE_W), .GALVO_W(GALVO_W), .MS_W(MS_W),
    .CLK_PER_MS(CPM), .SYNC_FILTER(SYNC_F)
  ) dut (
    .iCLK(clk), .iRST(rst),
    .iCAM_PULSE_MS(cam_ms), .iGALVO_PULSE_MS(galvo_ms),
    .iNUM_IMAGES(num_images), .iCYCLES_PER_IMAGE(cycles),
    .iNUM_GALVO_POS(num_pos), .iSETTLE_FRAMES(settle),
    .iGALVO_TIMEOUT_FRAMES(timeout),
    .iSTART(start), .iWITH_GALVO(with_galvo), .iABORT(abort),
    .iGALVO_ACK(galvo_ack), .iVGA_FRAME_SYNC(vga_sync),
    .oCAMERA_TRIGGER(cam_trig), .oGALVO_TRIGGER(galvo_trig),
    .oFRAME_ID(frame_id), .oGALVO_POS(galvo_pos),
    .oBUSY(busy), .oDONE(done), .oERR_TIMEOUT(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Frame sync: 100-cycle period, 20 cycles high, optional 1-cycle low dip.
  initial begin
    vga_sync = 1'b0;
    forever begin
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        vga_sync = (i < 20) && !(glitch_en && (i == 10));
        if (i == 20) frame_cnt++;
      end
    end
  end

  // Galvo responder: ack 30 cycles after each galvo pulse starts.
  initial begin
    bit prev;
    prev = 1'b0;
    galvo_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (galvo_trig && !prev && ack_en) begin
        repeat (30) @(negedge clk);
        galvo_ack = 1'b1;
        @(negedge clk);
        galvo_ack = 1'b0;
      end
      prev = galvo_trig;
    end
  end

  // Camera pulse monitor.
  initial begin
    bit prev; int w; int fid; int pos; pulse_exp_t e;
    prev = 1'b0; w = 0; fid = 0; pos = 0;
    forever begin
      @(negedge clk);
      if (cam_trig && !prev) begin
        w = 1; fid = int'(frame_id); pos = int'(galvo_pos);
      end else if (cam_trig) begin
        w++;
      end
      if (!cam_trig && prev) begin
        if (cam_q.size() == 0) check("cam_unexpected_pulse", 1, 0);
        else begin
          e = cam_q.pop_front();
          check("cam_frame_id", fid, e.fid);
          check("cam_galvo_pos", pos, e.pos);
          if (e.width >= 0) check("cam_width", w, e.width);
        end
      end
      prev = cam_trig;
    end
  end

  // Galvo pulse monitor.
  initial begin
    bit prev; int w; int pos; pulse_exp_t e;
    prev = 1'b0; w = 0; pos = 0;
    forever begin
      @(negedge clk);
      if (galvo_trig && !prev) begin
        w = 1; pos = int'(galvo_pos);
      end else if (galvo_trig) begin
        w++;
      end
      if (!galvo_trig && prev) begin
        if (gal_q.size() == 0) check("galvo_unexpected_pulse", 1, 0);
        else begin
          e = gal_q.pop_front();
          check("galvo_pos", pos, e.pos);
          check("galvo_width", w, e.width);
        end
      end
      prev = galvo_trig;
    end
  end

  // End-of-run monitor.
  initial begin
    done_exp_t e;
    forever begin
      @(negedge clk);
      if (done) begin
        if (done_q.size() == 0) check("done_unexpected", 1, 0);
        else begin
          e = done_q.pop_front();
          check("done_frame_id", frame_id, e.fid);
          check("done_galvo_pos", galvo_pos, e.pos);
          check("done_err", err, e.err);
          if (e.frames >= 0) check("done_frames", frame_cnt - start_frame, e.frames);
          if (e.max_lat > 0) check("done_latency", cyc - start_cyc, e.max_lat);
        end
        done_seen++;
      end
    end
  end

  // Run-level reference: what a configuration must produce, frame-counted.
  task automatic model_push(input cfg_t c);
    int npos;
    npos = c.galvo ? c.positions : 1;
    if (c.images == 0 || c.cycles == 0 || (c.galvo && c.positions == 0)) begin
      done_q.push_back('{fid: 0, pos: 0, err: 0, frames: 0, max_lat: 2});
      return;
    end
    for (int p = 0; p < npos; p++) begin
      if (c.galvo && c.galvo_ms > 0)
        gal_q.push_back('{fid: 0, pos: p, width: c.galvo_ms * CPM});
      for (int i = 0; i < c.images; i++)
        if (c.cam_ms > 0) cam_q.push_back('{fid: i, pos: p, width: c.cam_ms * CPM});
    end
    done_q.push_back('{fid: c.images - 1, pos: npos - 1, err: 0,
                       frames: npos * c.images * (c.settle + c.cycles), max_lat: 0});
  endtask

  task automatic recover();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cam_q.delete(); gal_q.delete(); done_q.delete();
  endtask

  task automatic start_run(input cfg_t c);
    int f;
    glitch_en  = c.glitch;
    ack_en     = c.ack;
    cam_ms     = MS_W'(c.cam_ms);
    galvo_ms   = MS_W'(c.galvo_ms);
    num_images = IMG_W'(c.images);
    cycles     = CYCLE_W'(c.cycles);
    num_pos    = GALVO_W'(c.positions);
    settle     = 4'(c.settle);
    timeout    = 8'(c.timeout);
    with_galvo = c.galvo;
    f = frame_cnt;
    while (frame_cnt == f) @(negedge clk);
    repeat (10) @(negedge clk);
    start_frame = frame_cnt;
    start_cyc   = cyc;
    done_target = done_seen + 1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("err_cleared_after_latch", err, 0);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done_seen < done_target && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    if (done_seen < done_target) begin
      check("done_within_bound", 0, 1);
      recover();
      return;
    end
    repeat (40) @(negedge clk);
    check("busy_after_done", busy, 0);
    check("cam_queue_drained", cam_q.size(), 0);
    check("galvo_queue_drained", gal_q.size(), 0);
  endtask

  task automatic wait_cam(input int fid, output bit ok);
    int n;
    n = 0;
    ok = 1'b0;
    while (n < BOUND) begin
      @(negedge clk);
      if (cam_trig && int'(frame_id) == fid) begin
        ok = 1'b1;
        return;
      end
      n++;
    end
  endtask

  initial begin
    cfg_t c;
    bit ok;
    rst = 1'b1;
    start = 1'b0; abort = 1'b0; with_galvo = 1'b0;
    cam_ms = '0; galvo_ms = '0; num_images = '0; cycles = '0;
    num_pos = '0; settle = '0; timeout = '0;
    repeat (3) @(negedge clk);
    check("rst_cam_trig", cam_trig, 0);
    check("rst_galvo_trig", galvo_trig, 0);
    check("rst_frame_id", frame_id, 0);
    check("rst_galvo_pos", galvo_pos, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // No galvo: 3 images, 2 frames each, settle 1, 20-cycle camera pulses.
    c = '{images: 3, cycles: 2, settle: 1, positions: 0, cam_ms: 2, galvo_ms: 0,
          timeout: 0, galvo: 0, ack: 0, glitch: 0};
    model_push(c); start_run(c); wait_done();

    // Galvo: 2 positions x 2 images with acks.
    c = '{images: 2, cycles: 1, settle: 1, positions: 2, cam_ms: 1, galvo_ms: 1,
          timeout: 0, galvo: 1, ack: 1, glitch: 0};
    model_push(c); start_run(c); wait_done();

    // Galvo timeout after 3 frame ends, no camera pulse, sticky flag.
    c = '{images: 1, cycles: 1, settle: 0, positions: 2, cam_ms: 1, galvo_ms: 1,
          timeout: 3, galvo: 1, ack: 0, glitch: 0};
    gal_q.push_back('{fid: 0, pos: 0, width: CPM});
    done_q.push_back('{fid: 0, pos: 0, err: 1, frames: 3, max_lat: 0});
    start_run(c); wait_done();
    check("err_sticky", err, 1);

    // Abort mid camera pulse on image 1; a start during the run is ignored.
    c = '{images: 3, cycles: 2, settle: 1, positions: 0, cam_ms: 2, galvo_ms: 0,
          timeout: 0, galvo: 0, ack: 0, glitch: 0};
    cam_q.push_back('{fid: 0, pos: 0, width: 2 * CPM});
    cam_q.push_back('{fid: 1, pos: 0, width: -1});
    done_q.push_back('{fid: 1, pos: 0, err: 0, frames: -1, max_lat: 0});
    start_run(c);
    check("err_cleared_by_start", err, 0);
    wait_cam(0, ok);
    check("abort_cam0_seen", ok, 1);
    start = 1'b1; with_galvo = 1'b1; num_images = IMG_W'(1);
    @(negedge clk);
    start = 1'b0;
    wait_cam(1, ok);
    check("abort_cam1_seen", ok, 1);
    repeat (5) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_cam_low", cam_trig, 0);
    check("abort_done", done, 1);
    @(negedge clk);
    check("abort_idle", busy, 0);
    wait_done();

    // Degenerate configurations end immediately with no pulses.
    c = '{images: 0, cycles: 2, settle: 1, positions: 0, cam_ms: 2, galvo_ms: 1,
          timeout: 0, galvo: 0, ack: 0, glitch: 0};
    model_push(c); start_run(c); wait_done();
    c.images = 2; c.cycles = 0;
    model_push(c); start_run(c); wait_done();
    c.cycles = 1; c.galvo = 1; c.positions = 0;
    model_push(c); start_run(c); wait_done();

    // Low glitch inside sync must not count as a frame end; ms=0 gives no pulse.
    c = '{images: 2, cycles: 1, settle: 0, positions: 0, cam_ms: 0, galvo_ms: 0,
          timeout: 0, galvo: 0, ack: 0, glitch: 1};
    model_push(c); start_run(c); wait_done();

    // Randomised runs.
    for (int r = 0; r < 4; r++) begin
      c.images    = int'($urandom_range(1, 3));
      c.cycles    = int'($urandom_range(1, 2));
      c.settle    = int'($urandom_range(0, 2));
      c.cam_ms    = int'($urandom_range(0, 3));
      c.galvo     = 1'($urandom_range(0, 1));
      c.positions = int'($urandom_range(1, 2));
      c.galvo_ms  = int'($urandom_range(1, 2));
      c.timeout   = ($urandom_range(0, 1) == 1) ? 5 : 0;
      c.ack       = c.galvo;
      c.glitch    = 1'($urandom_range(0, 1));
      model_push(c); start_run(c); wait_done();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
